// File: rtl/mc_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives memory handshakes and datapath strobes, halts on faults.
module mc_control_fsm #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CW          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [1:0] dmem_size,
  input  logic       dmem_ready,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_b,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OP, C_OPIMM, C_FENCE, C_SYSTEM
  } cls_t;

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYC - 1);

  state_t        state_q;
  cls_t          cls_q;
  cls_t          cls_dec;
  logic [1:0]    size_q;
  logic [CW-1:0] wd_q;
  logic          illegal_q;
  logic          bus_err_q;
  logic          wd_expire;

  always_comb begin
    cls_dec = C_NONE;
    case (opcode)
      7'b0110111: cls_dec = C_LUI;
      7'b0010111: cls_dec = C_AUIPC;
      7'b1101111: cls_dec = C_JAL;
      7'b1100111: cls_dec = C_JALR;
      7'b1100011: cls_dec = C_BRANCH;
      7'b0110011: cls_dec = C_OP;
      7'b0010011: cls_dec = C_OPIMM;
      7'b0001111: cls_dec = C_FENCE;
      7'b1110011: cls_dec = C_SYSTEM;
      7'b0000011: if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) cls_dec = C_LOAD;
      7'b0100011: if (funct3 <= 3'd2) cls_dec = C_STORE;
      default:    cls_dec = C_NONE;
    endcase
  end

  // Expiry is judged on the wait cycle that would bring the count to TIMEOUT_CYC,
  // so a ready in that same cycle still completes the handshake.
  assign wd_expire = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      size_q    <= '0;
      wd_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          wd_q    <= '0;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state_q <= S_DECODE;
          end else if (wd_expire) begin
            bus_err_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_DECODE: begin
          cls_q  <= cls_dec;
          size_q <= funct3[1:0];
          case (cls_dec)
            C_NONE: begin
              illegal_q <= 1'b1;
              state_q   <= S_HALT;
            end
            C_SYSTEM: state_q <= S_HALT;
            default:  state_q <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          wd_q <= '0;
          case (cls_q)
            C_BRANCH, C_FENCE: state_q <= S_FETCH;
            C_LOAD, C_STORE:   state_q <= S_MEM;
            default:           state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            wd_q    <= '0;
            state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
          end else if (wd_expire) begin
            bus_err_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_WB: begin
          wd_q    <= '0;
          state_q <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_size = '0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = '0;
    rf_we     = 1'b0;
    wb_sel    = '0;
    alu_src_b = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        alu_src_b = !(cls_q == C_OP || cls_q == C_BRANCH);
        if (cls_q == C_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = {1'b0, br_taken};
        end else if (cls_q == C_FENCE) begin
          pc_we = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = (cls_q == C_STORE);
        dmem_size = size_q;
        pc_we     = dmem_ready && (cls_q == C_STORE);
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (cls_q == C_JAL || cls_q == C_JALR) wb_sel = 2'd2;
        else if (cls_q == C_LOAD)              wb_sel = 2'd1;
        if (cls_q == C_JAL)       pc_sel = 2'd1;
        else if (cls_q == C_JALR) pc_sel = 2'd2;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed instruction sequences with literal expectations,
// then randomized traffic checked every cycle against a phase-level reference model.
module tb_mc_control_fsm;
  localparam int unsigned T = 4;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_OPI   = 7'b0010011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic clk = 1'b0;
  logic rst, br_taken, imem_ready, dmem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_src_b, illegal, bus_err, halted;
  logic [1:0] dmem_size, pc_sel, wb_sel;
  logic [2:0] state_o;

  mc_control_fsm #(.TIMEOUT_CYC(T), .CW(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_size(dmem_size), .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .illegal(illegal), .bus_err(bus_err), .halted(halted), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req, ir_we, dmem_req, dmem_we;
    logic [1:0] dmem_size;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       alu_src_b, illegal, bus_err, halted;
    logic [2:0] state;
  } outs_t;

  int vectors = 0;
  int miscompares = 0;
  outs_t act;

  // Reference model: phase number (0..6 as exposed on state_o), captured instruction,
  // wait cycles spent in the current handshake, and the sticky fault flags.
  int         mph = 0;
  logic [6:0] mop = '0;
  logic [2:0] mf3 = '0;
  int         mwait = 0;
  bit         mill = 0, mberr = 0;

  task automatic chk(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // 0 = illegal, 1 = executes, 2 = SYSTEM (halts cleanly)
  function automatic int kind(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_OP, OP_OPI, OP_FENCE: return 1;
      OP_LD:   return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 0 : 1;
      OP_ST:   return (f3 <= 3'd2) ? 1 : 0;
      OP_SYS:  return 2;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    outs_t e;
    int prev;
    @(negedge clk);
    if (rst) begin
      mph = 0; mill = 0; mberr = 0; mwait = 0;
    end
    e = '0;
    e.state   = 3'(mph);
    e.illegal = mill;
    e.bus_err = mberr;
    case (mph)
      1: begin e.imem_req = 1; e.ir_we = imem_ready; end
      3: begin
        e.alu_src_b = !(mop == OP_OP || mop == OP_BR);
        if (mop == OP_BR) begin e.pc_we = 1; e.pc_sel = {1'b0, br_taken}; end
        if (mop == OP_FENCE) e.pc_we = 1;
      end
      4: begin
        e.dmem_req = 1; e.dmem_we = (mop == OP_ST); e.dmem_size = mf3[1:0];
        e.pc_we = dmem_ready && (mop == OP_ST);
      end
      5: begin
        e.rf_we = 1; e.pc_we = 1;
        e.wb_sel = (mop == OP_JAL || mop == OP_JALR) ? 2'd2 : (mop == OP_LD) ? 2'd1 : 2'd0;
        e.pc_sel = (mop == OP_JAL) ? 2'd1 : (mop == OP_JALR) ? 2'd2 : 2'd0;
      end
      6: e.halted = 1;
      default: ;
    endcase
    act = '{imem_req, ir_we, dmem_req, dmem_we, dmem_size, pc_we, pc_sel, rf_we, wb_sel,
            alu_src_b, illegal, bus_err, halted, state_o};
    chk("imem_req", act.imem_req, e.imem_req);
    chk("ir_we", act.ir_we, e.ir_we);
    chk("dmem_req", act.dmem_req, e.dmem_req);
    chk("dmem_we", act.dmem_we, e.dmem_we);
    chk("dmem_size", act.dmem_size, e.dmem_size);
    chk("pc_we", act.pc_we, e.pc_we);
    chk("pc_sel", act.pc_sel, e.pc_sel);
    chk("rf_we", act.rf_we, e.rf_we);
    chk("wb_sel", act.wb_sel, e.wb_sel);
    chk("alu_src_b", act.alu_src_b, e.alu_src_b);
    chk("illegal", act.illegal, e.illegal);
    chk("bus_err", act.bus_err, e.bus_err);
    chk("halted", act.halted, e.halted);
    chk("state_o", act.state, e.state);
    if (!rst) begin
      prev = mph;
      case (mph)
        0: mph = 1;
        1: begin
          if (imem_ready) mph = 2;
          else if (T != 0 && mwait + 1 == int'(T)) begin mberr = 1; mph = 6; end
          else mwait++;
        end
        2: begin
          mop = opcode; mf3 = funct3;
          case (kind(opcode, funct3))
            1: mph = 3;
            2: mph = 6;
            default: begin mph = 6; mill = 1; end
          endcase
        end
        3: mph = (mop == OP_BR || mop == OP_FENCE) ? 1 : (mop == OP_LD || mop == OP_ST) ? 4 : 5;
        4: begin
          if (dmem_ready) mph = (mop == OP_ST) ? 1 : 5;
          else if (T != 0 && mwait + 1 == int'(T)) begin mberr = 1; mph = 6; end
          else mwait++;
        end
        5: mph = 1;
        default: ;
      endcase
      if (mph != prev) mwait = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic dr, input logic bt);
    imem_ready = ir; dmem_ready = dr; br_taken = bt;
  endtask

  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3);
    opcode = op; funct3 = f3;
    drive(1, 0, 0); step();
    drive(0, 0, 0); step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step();
    rst = 1'b0; step();
  endtask

  task automatic pick_instr();
    int r;
    logic [6:0] legal [10];
    legal = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_OP, OP_OPI, OP_FENCE};
    r = $urandom_range(0, 19);
    if (r < 16) begin
      opcode = legal[$urandom_range(0, 9)];
      funct3 = 3'($urandom_range(0, 7));
      if (opcode == OP_ST) funct3 = 3'($urandom_range(0, 2));
      if (opcode == OP_LD) begin
        funct3 = 3'($urandom_range(0, 4));
        if (funct3 == 3'd3) funct3 = 3'd5;
      end
    end else if (r == 16) begin
      opcode = OP_SYS; funct3 = 3'($urandom_range(0, 7));
    end else if (r == 17) begin
      opcode = OP_LD; funct3 = 3'($urandom_range(6, 7));
    end else begin
      opcode = 7'($urandom_range(0, 127)); funct3 = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    rst = 1'b0; opcode = '0; funct3 = '0; drive(0, 0, 0);
    #1 rst = 1'b1;
    step();
    chk("reset_state", act.state, 0);
    chk("reset_imem_req", act.imem_req, 0);
    rst = 1'b0;
    step();
    chk("idle_state", act.state, 0);

    // ADDI with zero-wait fetch: FETCH at cycle 1, WB at cycle 4
    opcode = OP_OPI; funct3 = 3'd0; drive(1, 0, 0); step();
    chk("addi_c1_imem_req", act.imem_req, 1);
    chk("addi_c1_ir_we", act.ir_we, 1);
    drive(0, 0, 0); step();
    chk("addi_c2_state", act.state, 2);
    step();
    chk("addi_c3_alu_src_b", act.alu_src_b, 1);
    step();
    chk("addi_c4_rf_we", act.rf_we, 1);
    chk("addi_c4_wb_sel", act.wb_sel, 0);
    chk("addi_c4_pc_we", act.pc_we, 1);
    chk("addi_c4_pc_sel", act.pc_sel, 0);

    for (int t = 1; t >= 0; t--) begin
      fetch_decode(OP_BR, 3'd0);
      drive(0, 0, 1'(t)); step();
      chk("beq_pc_we", act.pc_we, 1);
      chk("beq_pc_sel", act.pc_sel, t);
      chk("beq_rf_we", act.rf_we, 0);
      chk("beq_alu_src_b", act.alu_src_b, 0);
    end
    drive(0, 0, 0);

    fetch_decode(OP_LD, 3'd2);
    step();
    chk("lw_exec_state", act.state, 3);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) drive(0, 1, 0);
      step();
      chk("lw_dmem_req", act.dmem_req, 1);
      chk("lw_dmem_we", act.dmem_we, 0);
      chk("lw_dmem_size", act.dmem_size, 2);
    end
    drive(0, 0, 0); step();
    chk("lw_wb_sel", act.wb_sel, 1);
    chk("lw_rf_we", act.rf_we, 1);

    fetch_decode(OP_ST, 3'd0);
    step();
    drive(0, 1, 0); step();
    chk("sb_dmem_we", act.dmem_we, 1);
    chk("sb_dmem_size", act.dmem_size, 0);
    chk("sb_pc_we", act.pc_we, 1);
    chk("sb_pc_sel", act.pc_sel, 0);
    chk("sb_rf_we", act.rf_we, 0);
    drive(0, 0, 0);

    fetch_decode(OP_JALR, 3'd0);
    step(); step();
    chk("jalr_wb_sel", act.wb_sel, 2);
    chk("jalr_pc_sel", act.pc_sel, 2);
    chk("jalr_rf_we", act.rf_we, 1);
    chk("jalr_pc_we", act.pc_we, 1);

    fetch_decode(7'h7F, 3'd0);
    step();
    chk("ill7f_halted", act.halted, 1);
    chk("ill7f_illegal", act.illegal, 1);
    drive(1, 1, 1);
    repeat (3) begin
      step();
      chk("ill7f_no_imem_req", act.imem_req, 0);
    end
    drive(0, 0, 0);
    do_reset();
    chk("post_reset_illegal", act.illegal, 0);

    fetch_decode(OP_LD, 3'd3);
    step();
    chk("ldf3_halted", act.halted, 1);
    chk("ldf3_illegal", act.illegal, 1);
    do_reset();

    // Watchdog: four starved fetch cycles, then HALT with bus_err
    drive(0, 0, 0);
    repeat (4) begin
      step();
      chk("wd_wait_imem_req", act.imem_req, 1);
      chk("wd_wait_bus_err", act.bus_err, 0);
    end
    step();
    chk("wd_halted", act.halted, 1);
    chk("wd_bus_err", act.bus_err, 1);
    chk("wd_imem_req", act.imem_req, 0);
    do_reset();

    opcode = OP_OPI; funct3 = 3'd0;
    repeat (3) step();
    drive(1, 0, 0); step();
    chk("wd_late_ir_we", act.ir_we, 1);
    drive(0, 0, 0); step();
    chk("wd_late_state", act.state, 2);
    chk("wd_late_bus_err", act.bus_err, 0);
    step(); step();

    fetch_decode(OP_LD, 3'd0);
    step(); step();
    chk("midmem_dmem_req", act.dmem_req, 1);
    rst = 1'b1; step();
    chk("midmem_rst_dmem_req", act.dmem_req, 0);
    chk("midmem_rst_rf_we", act.rf_we, 0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      if (rst) rst = 1'b0;
      else if ((mph == 6 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) rst = 1'b1;
      if (mph == 1 && mwait == 0) pick_instr();
      imem_ready = ($urandom_range(0, 2) != 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      br_taken   = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
